drv_ad56x3: RTL and testbench
=============================

Name: drv_ad56x3

Overview:
- SPI write driver for AD5623/AD5643/AD5663 dual DACs.
- Accepts channel A and channel B samples over a valid/ready stream interface.
- Converts each sample to the DAC 16-bit code and serializes two 24-bit frames: channel A first, then channel B.
- Sits between the DSP datapath and the DAC pins (SYNC, SCLK, DIN).

Parameters:
- SIGN_A, "UNSIGNED", channel A input format: "SIGNED" (two's complement) or "UNSIGNED".
- SIGN_B, "UNSIGNED", channel B input format, same encoding.
- DATA_WIDTH, 16, input sample width: 12, 14 or 16.
- SCLK_DIVIDER, 2, clk cycles per SCLK half-period (one "tick"); must be ≥1.
- SYNC_DURATION, 5, ticks SYNC is held high between frames; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- asiValid  in  1  sample valid.
- asiChannel  in  1  0 = channel A, 1 = channel B.
- asiData  in  DATA_WIDTH  sample.
- asiRdy  out  1  driver ready to accept a sample pair.
- dacSync  out  1  DAC SYNC, active low.
- dacSclk  out  1  DAC SCLK, idles high.
- dacDin  out  1  DAC serial data, MSB first.

Behaviour:
- Reset state (reset is asynchronous, active-high; clock is clk):
  - asiRdy=0, dacSync=1, dacSclk=1, dacDin=0.
  - State IDLE; A and B data registers = 0.
  - asiRdy rises on the first clk edge after reset release.
- Named constants:
  - COMMAND_WORD_A=3'b000 (write input register).
  - ADDRESS_WORD_A=3'b000.
  - COMMAND_WORD_B=3'b010 (write input register, update all, so both outputs change together).
  - ADDRESS_WORD_B=3'b001.
- Code conversion:
  - code16 = {asiData[DATA_WIDTH-1] XOR signed, asiData[DATA_WIDTH-2:0], (16-DATA_WIDTH) zeros}.
  - signed = 1 when the channel's SIGN is "SIGNED"; this maps two's complement to offset binary.
  - Conversion is registered at acceptance.
- Frame format (24 bits): {2'b00, COMMAND, ADDRESS, code16}.
- Handshake:
  - In IDLE with asiRdy=1, asiValid with asiChannel=0 latches frame A. asiRdy stays high.
  - asiValid with asiChannel=1 latches frame B and starts transfer. asiRdy=0 from the next cycle.
  - A and B may arrive on consecutive cycles.
  - If B arrives without a new A, the last latched A (reset value 0) is resent.
  - asiValid while asiRdy=0 is ignored.
- States: IDLE → SHIFT_A → GAP_A → SHIFT_B → GAP_B → IDLE.
- Tick generation: a tick counter counts SCLK_DIVIDER clk cycles and restarts on transfer start.
- SHIFT phase:
  - dacSync goes low the cycle after B acceptance, with dacSclk=1 and dacDin=bit23.
  - Each frame is 48 ticks alternating SCLK low (DAC samples on falling edge), then SCLK high with dacDin advancing to the next bit.
  - Exactly 24 falling edges occur while dacSync is low.
  - dacSync returns high together with the final SCLK rising edge, i.e. 48 ticks after falling.
- GAP phase: dacSync=1, dacSclk=1 for SYNC_DURATION ticks.
- After GAP_B, asiRdy=1 and the state is IDLE.
- Total busy time: SCLK_DIVIDER*(96+2*SYNC_DURATION) clk cycles.
- dacDin outside frames = 0.
- Reset mid-transfer aborts immediately to reset values. No partial frame is resumed.

Optional Feature:
- Macro DRV_AD56X3_CHECKS_EN.
- When defined, simulation-only checks are compiled in:
  - $error at elaboration if DATA_WIDTH is not 12/14/16, or SCLK_DIVIDER<1, or SYNC_DURATION<1, or SIGN_x is not "SIGNED"/"UNSIGNED".
  - $warning at runtime when asiValid=1 while asiRdy=0 (dropped sample).
- When undefined: no checks, identical synthesized logic.

Test Plan:
- Reset for 10 clk → dacSync=1, dacSclk=1, dacDin=0, asiRdy=0; asiRdy=1 one clk after release.
- DATA_WIDTH=14, SIGN_A UNSIGNED, SIGN_B SIGNED, A=14'h1234, B=14'h2001 on consecutive cycles:
  - Frame A on falling SCLK edges = 24'h0048D0.
  - Frame B = 24'h110004.
- Timing with SCLK_DIVIDER=2, SYNC_DURATION=5:
  - SYNC low 96 clk per frame, high 10 clk between frames.
  - asiRdy returns high 212 clk after B acceptance.
  - 24 SCLK falling edges per SYNC-low window.
- Pulse asiValid during busy → ignored; next frames still carry the original data.
- Send B only, after a prior A=14'h0000 with SIGN_A UNSIGNED → frame A=24'h000000, then frame B is sent.
- Assert reset mid-SHIFT_B → outputs return to reset values within the same cycle. The next full pair transfers correctly.
- Randomized back-to-back pairs (≥100) → decoded frames match the conversion rule for both channels.

Source files
------------

// File: rtl/drv_ad56x3.sv
// drv_ad56x3: SPI write driver for AD5623/AD5643/AD5663 dual DACs.
// Takes a channel A / channel B sample pair over a valid/ready stream,
// converts each sample to a 16-bit DAC code and shifts out two 24-bit frames
// (A first, then B). Channel B uses "write input register, update all" so both
// DAC outputs change together.
// Optional macro DRV_AD56X3_CHECKS_EN compiles in simulation-only parameter
// and dropped-sample checks; the synthesized logic is the same either way.
module drv_ad56x3 #(
  parameter string SIGN_A        = "UNSIGNED",
  parameter string SIGN_B        = "UNSIGNED",
  parameter int    DATA_WIDTH    = 16,
  parameter int    SCLK_DIVIDER  = 2,
  parameter int    SYNC_DURATION = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  asiValid,
  input  logic                  asiChannel,
  input  logic [DATA_WIDTH-1:0] asiData,
  output logic                  asiRdy,
  output logic                  dacSync,
  output logic                  dacSclk,
  output logic                  dacDin
);

  localparam logic [2:0] COMMAND_WORD_A = 3'b000;
  localparam logic [2:0] ADDRESS_WORD_A = 3'b000;
  localparam logic [2:0] COMMAND_WORD_B = 3'b010;
  localparam logic [2:0] ADDRESS_WORD_B = 3'b001;

  localparam bit SIGNED_A = (SIGN_A == "SIGNED");
  localparam bit SIGNED_B = (SIGN_B == "SIGNED");

  localparam int TICK_W = (SCLK_DIVIDER > 1) ? $clog2(SCLK_DIVIDER) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCLK_DIVIDER - 1);

  // A frame is 48 ticks: 24 SCLK low halves and 24 SCLK high halves.
  localparam logic [15:0] SHIFT_LAST = 16'd47;
  localparam logic [15:0] GAP_LAST   = 16'(SYNC_DURATION - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_A,
    GAP_A,
    SHIFT_B,
    GAP_B
  } StateType;

  StateType          state, stateNext;
  logic [TICK_W-1:0] tickCnt, tickCntNext;
  logic [15:0]       phaseCnt, phaseCntNext;
  logic [23:0]       frameA, frameANext;
  logic [23:0]       frameB, frameBNext;
  logic [23:0]       shiftReg, shiftRegNext;
  logic              rdyNext, syncNext, sclkNext, dinNext;
  logic              tick;

  logic                  signFlip;
  logic [DATA_WIDTH-1:0] flipped;
  logic [15:0]           code16;
  logic [23:0]           newFrame;

  assign tick = (tickCnt == TICK_LAST);

  // Sample-to-frame conversion: flip the MSB for signed channels (two's
  // complement to offset binary), left-justify into 16 bits, add the header.
  always_comb begin
    signFlip = asiChannel ? SIGNED_B : SIGNED_A;
    flipped  = asiData;
    flipped[DATA_WIDTH-1] = asiData[DATA_WIDTH-1] ^ signFlip;
    code16   = 16'(flipped) << (16 - DATA_WIDTH);
    if (asiChannel)
      newFrame = {2'b00, COMMAND_WORD_B, ADDRESS_WORD_B, code16};
    else
      newFrame = {2'b00, COMMAND_WORD_A, ADDRESS_WORD_A, code16};
  end

  // Next-state and next-output logic; all pin outputs are registered so the
  // DAC sees glitch-free SYNC/SCLK/DIN.
  always_comb begin
    stateNext    = state;
    tickCntNext  = tick ? '0 : tickCnt + 1'b1;
    phaseCntNext = phaseCnt;
    frameANext   = frameA;
    frameBNext   = frameB;
    shiftRegNext = shiftReg;
    rdyNext      = asiRdy;
    syncNext     = dacSync;
    sclkNext     = dacSclk;
    dinNext      = dacDin;

    case (state)
      IDLE: begin
        tickCntNext  = '0;
        phaseCntNext = '0;
        rdyNext      = 1'b1;
        syncNext     = 1'b1;
        sclkNext     = 1'b1;
        dinNext      = 1'b0;
        if (asiRdy && asiValid) begin
          if (!asiChannel) begin
            frameANext = newFrame;
          end else begin
            frameBNext   = newFrame;
            shiftRegNext = frameA;
            dinNext      = frameA[23];
            syncNext     = 1'b0;
            rdyNext      = 1'b0;
            stateNext    = SHIFT_A;
          end
        end
      end

      SHIFT_A, SHIFT_B: begin
        if (tick) begin
          phaseCntNext = phaseCnt + 1'b1;
          if (phaseCnt == SHIFT_LAST) begin
            phaseCntNext = '0;
            syncNext     = 1'b1;
            sclkNext     = 1'b1;
            dinNext      = 1'b0;
            stateNext    = (state == SHIFT_A) ? GAP_A : GAP_B;
          end else if (!phaseCnt[0]) begin
            sclkNext = 1'b0;
          end else begin
            sclkNext     = 1'b1;
            shiftRegNext = {shiftReg[22:0], 1'b0};
            dinNext      = shiftReg[22];
          end
        end
      end

      GAP_A: begin
        if (tick) begin
          phaseCntNext = phaseCnt + 1'b1;
          if (phaseCnt == GAP_LAST) begin
            phaseCntNext = '0;
            shiftRegNext = frameB;
            dinNext      = frameB[23];
            syncNext     = 1'b0;
            sclkNext     = 1'b1;
            stateNext    = SHIFT_B;
          end
        end
      end

      GAP_B: begin
        if (tick) begin
          phaseCntNext = phaseCnt + 1'b1;
          if (phaseCnt == GAP_LAST) begin
            phaseCntNext = '0;
            rdyNext      = 1'b1;
            stateNext    = IDLE;
          end
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tickCnt  <= '0;
      phaseCnt <= '0;
      frameA   <= '0;
      frameB   <= '0;
      shiftReg <= '0;
      asiRdy   <= 1'b0;
      dacSync  <= 1'b1;
      dacSclk  <= 1'b1;
      dacDin   <= 1'b0;
    end else begin
      state    <= stateNext;
      tickCnt  <= tickCntNext;
      phaseCnt <= phaseCntNext;
      frameA   <= frameANext;
      frameB   <= frameBNext;
      shiftReg <= shiftRegNext;
      asiRdy   <= rdyNext;
      dacSync  <= syncNext;
      dacSclk  <= sclkNext;
      dacDin   <= dinNext;
    end
  end

`ifdef DRV_AD56X3_CHECKS_EN
  if (!(DATA_WIDTH == 12 || DATA_WIDTH == 14 || DATA_WIDTH == 16)) begin : gBadWidth
    $error("drv_ad56x3: DATA_WIDTH must be 12, 14 or 16");
  end
  if (SCLK_DIVIDER < 1) begin : gBadDivider
    $error("drv_ad56x3: SCLK_DIVIDER must be at least 1");
  end
  if (SYNC_DURATION < 1) begin : gBadSync
    $error("drv_ad56x3: SYNC_DURATION must be at least 1");
  end
  if (SIGN_A != "SIGNED" && SIGN_A != "UNSIGNED") begin : gBadSignA
    $error("drv_ad56x3: SIGN_A must be SIGNED or UNSIGNED");
  end
  if (SIGN_B != "SIGNED" && SIGN_B != "UNSIGNED") begin : gBadSignB
    $error("drv_ad56x3: SIGN_B must be SIGNED or UNSIGNED");
  end

  // Flag samples offered while the driver is busy; they are dropped.
  always_ff @(posedge clk) begin
    if (!reset && asiValid && !asiRdy)
      $warning("drv_ad56x3: sample dropped, asiValid while asiRdy=0");
  end
`else
  // Default build: no checks.
`endif

endmodule

// File: tb/tb_drv_ad56x3.sv
// tb_drv_ad56x3: scoreboard bench for drv_ad56x3 (14-bit, A unsigned,
// B signed, SCLK_DIVIDER=2, SYNC_DURATION=5). Stimulus pushes expected frames
// into a queue; a monitor decodes SPI frames off the pins and compares.
module tb_drv_ad56x3;

  logic        clk;
  logic        reset;
  logic        asiValid;
  logic        asiChannel;
  logic [13:0] asiData;
  logic        asiRdy;
  logic        dacSync;
  logic        dacSclk;
  logic        dacDin;

  int          checks   = 0;
  int          failures = 0;
  logic [23:0] expQ[$];
  logic [23:0] tbLastA;

  drv_ad56x3 #(
    .SIGN_A       ("UNSIGNED"),
    .SIGN_B       ("SIGNED"),
    .DATA_WIDTH   (14),
    .SCLK_DIVIDER (2),
    .SYNC_DURATION(5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .asiValid  (asiValid),
    .asiChannel(asiChannel),
    .asiData   (asiData),
    .asiRdy    (asiRdy),
    .dacSync   (dacSync),
    .dacSclk   (dacSclk),
    .dacDin    (dacDin)
  );

  // 100 MHz system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected 24-bit frame: left-justify 14 bits, channel B is signed so its
  // MSB is inverted, header 0x00 for A and 0x11 for B.
  function automatic logic [23:0] expFrame(input logic ch, input logic [13:0] d);
    logic [15:0] code;
    code = {d, 2'b00};
    if (ch) code[15] = ~code[15];
    return ch ? {8'h11, code} : {8'h00, code};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic waitRdy();
    int n;
    n = 0;
    while (!asiRdy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rdy wait", asiRdy, 1);
  endtask

  // Send an optional A sample then a B sample; optionally time the busy window.
  task automatic applyStimulus(input logic [13:0] a, input logic [13:0] b,
                               input bit sendA, input bit measure);
    int n;
    waitRdy();
    if (sendA) begin
      asiValid   = 1'b1;
      asiChannel = 1'b0;
      asiData    = a;
      tbLastA    = expFrame(1'b0, a);
      @(negedge clk);
    end
    asiValid   = 1'b1;
    asiChannel = 1'b1;
    asiData    = b;
    expQ.push_back(tbLastA);
    expQ.push_back(expFrame(1'b1, b));
    @(negedge clk);
    asiValid = 1'b0;
    if (measure) begin
      checkOutput("rdy drop", asiRdy, 0);
      n = 0;
      while (!asiRdy && n < 400) begin
        @(negedge clk);
        n++;
      end
      checkOutput("busy clk", n, 212);
    end
  endtask

  // Monitor: decode frames on SCLK falling edges while SYNC is low.
  initial begin : monitor
    logic        prevSync, prevSclk, inGap, phaseB;
    logic [23:0] bits;
    int          nFall, lowCnt, gapCnt;
    prevSync = 1'b1; prevSclk = 1'b1; inGap = 1'b0; phaseB = 1'b0;
    bits = '0; nFall = 0; lowCnt = 0; gapCnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevSync = 1'b1; prevSclk = 1'b1; inGap = 1'b0; phaseB = 1'b0;
      end else begin
        if (!dacSync) begin
          if (prevSync) begin
            if (inGap) checkOutput("sync gap clk", gapCnt, 10);
            inGap = 1'b0; bits = '0; nFall = 0; lowCnt = 0;
          end
          lowCnt++;
          if (prevSclk && !dacSclk) begin
            bits = {bits[22:0], dacDin};
            nFall++;
          end
        end else begin
          if (!prevSync) begin
            if (expQ.size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL frame unexpected: got %06h, none expected", bits);
            end else begin
              checkOutput(phaseB ? "frame B" : "frame A", bits, expQ.pop_front());
            end
            checkOutput("falling edges", nFall, 24);
            checkOutput("sync low clk", lowCnt, 96);
            checkOutput("idle sclk", dacSclk, 1);
            checkOutput("idle din", dacDin, 0);
            inGap  = !phaseB;
            gapCnt = 1;
            phaseB = !phaseB;
          end else if (inGap) begin
            gapCnt++;
          end
        end
        prevSync = dacSync;
        prevSclk = dacSclk;
      end
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence, then back-to-back pairs.
  initial begin
    reset = 1'b1; asiValid = 1'b0; asiChannel = 1'b0; asiData = '0;
    tbLastA = '0;
    repeat (10) @(negedge clk);
    checkOutput("reset sync", dacSync, 1);
    checkOutput("reset sclk", dacSclk, 1);
    checkOutput("reset din", dacDin, 0);
    checkOutput("reset rdy", asiRdy, 0);
    reset = 1'b0;
    #1 checkOutput("rdy before edge", asiRdy, 0);
    @(negedge clk);
    checkOutput("rdy after release", asiRdy, 1);

    // Reference pair with busy-time measurement.
    applyStimulus(14'h1234, 14'h2001, 1'b1, 1'b1);

    // Samples offered while busy must be ignored.
    applyStimulus(14'h3FFF, 14'h0000, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    asiValid = 1'b1; asiChannel = 1'b0; asiData = 14'h0555;
    @(negedge clk);
    asiChannel = 1'b1; asiData = 14'h1234;
    @(negedge clk);
    asiValid = 1'b0;
    applyStimulus(14'h0000, 14'h1FFF, 1'b0, 1'b0);

    // B only after A=0: A frame resent as all zeros.
    applyStimulus(14'h0000, 14'h3FFF, 1'b1, 1'b0);
    applyStimulus(14'h0000, 14'h2000, 1'b0, 1'b0);

    // Reset in the middle of frame B.
    applyStimulus(14'h0ABC, 14'h1555, 1'b1, 1'b0);
    repeat (130) @(negedge clk);
    #1 reset = 1'b1;
    expQ.delete();
    tbLastA = '0;
    #1;
    checkOutput("abort sync", dacSync, 1);
    checkOutput("abort sclk", dacSclk, 1);
    checkOutput("abort din", dacDin, 0);
    checkOutput("abort rdy", asiRdy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    applyStimulus(14'h1234, 14'h2001, 1'b1, 1'b0);

    // Back-to-back pairs.
    for (int i = 0; i < 100; i++) begin
      applyStimulus(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)), 1'b1, 1'b0);
    end

    waitRdy();
    checkOutput("queue empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
